// File: rtl/priority_event_encoder.sv
// priority_event_encoder
// Sequential 8-to-3 priority encoder. Event requests accumulate in a pending
// register; the highest-index eligible pending event is moved into a held
// binary code and offered to a single consumer over a valid/ready handshake.
// The produced code is the inverse of the downstream 3-to-8 one-hot priority
// decode, so codes can be fed straight back into that decoder.

module priority_event_encoder #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  output logic [W-1:0] code,
  output logic         code_valid,
  input  logic         code_ready,
  output logic [N-1:0] pending,
  output logic         overflow,
  input  logic         clr_ovf
);

  // IDLE: nothing offered to the consumer. HOLD: code holds an undelivered event.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Index of the highest set bit; bit N-1 has top priority. Returns 0 for an
  // all-zero vector, callers only use the result when the vector is non-zero.
  function automatic logic [W-1:0] f_highest_idx(input logic [N-1:0] v);
    logic [W-1:0] idx;
    idx = {W{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        idx = W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // One-hot expansion of a line index, used to clear the dispatched pending bit.
  function automatic logic [N-1:0] f_onehot(input logic [W-1:0] idx);
    logic [N-1:0] v;
    v      = {N{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  state_t       r_state;
  logic [W-1:0] r_code;
  logic         r_code_valid;
  logic [N-1:0] r_pending;
  logic         r_overflow;

  state_t       w_state_nxt;
  logic [N-1:0] w_elig;
  logic         w_elig_any;
  logic         w_handshake;
  logic         w_dispatch;
  logic [W-1:0] w_sel_idx;
  logic [N-1:0] w_take;
  logic [N-1:0] w_pending_nxt;
  logic [W-1:0] w_code_nxt;
  logic         w_code_valid_nxt;
  logic [N-1:0] w_ovf_coalesce;
  logic         w_ovf_held;
  logic         w_ovf_set;
  logic         w_overflow_nxt;

  // Eligibility, handshake detection and selection of the next code to dispatch.
  always_comb begin
    w_elig      = r_pending & ~mask;
    w_elig_any  = |w_elig;
    w_handshake = r_code_valid & code_ready;
    w_sel_idx   = f_highest_idx(w_elig);
  end

  // Next-state logic: load from IDLE, hold until accepted, reload back-to-back.
  always_comb begin
    w_state_nxt = r_state;
    w_dispatch  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_elig_any) begin
          w_dispatch  = 1'b1;
          w_state_nxt = ST_HOLD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (w_handshake) begin
          if (w_elig_any) begin
            w_dispatch  = 1'b1;
            w_state_nxt = ST_HOLD;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          // A held code is never withdrawn, whatever the mask does.
          w_state_nxt = ST_HOLD;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Datapath next values: code, valid, pending bookkeeping and overflow.
  always_comb begin
    if (w_dispatch) begin
      w_take     = f_onehot(w_sel_idx);
      w_code_nxt = w_sel_idx;
    end else begin
      w_take     = {N{1'b0}};
      w_code_nxt = r_code;
    end

    w_code_valid_nxt = (w_state_nxt == ST_HOLD);

    // A request on the bit being taken this edge re-arms it: the new event is kept.
    w_pending_nxt = (r_pending & ~w_take) | req;

    // Coalesced event: request on a line already pending and not leaving this edge.
    w_ovf_coalesce = req & r_pending & ~w_take;

    // Request on the held line while it is still offered and already pending again.
    if (r_code_valid && !w_handshake) begin
      w_ovf_held = req[r_code] & r_pending[r_code];
    end else begin
      w_ovf_held = 1'b0;
    end

    w_ovf_set = (|w_ovf_coalesce) | w_ovf_held;

    // A set condition on the same edge beats the clear.
    if (w_ovf_set) begin
      w_overflow_nxt = 1'b1;
    end else if (clr_ovf) begin
      w_overflow_nxt = 1'b0;
    end else begin
      w_overflow_nxt = r_overflow;
    end
  end

  // State register; reset discards any held code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_code_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_code_valid <= w_code_valid_nxt;
    end
  end

  // Code register; keeps its last value after the consumer drains it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_code <= {W{1'b0}};
    end else begin
      r_code <= w_code_nxt;
    end
  end

  // Pending register; reset discards all outstanding events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= {N{1'b0}};
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  // Sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_overflow_nxt;
    end
  end

  assign code       = r_code;
  assign code_valid = r_code_valid;
  assign pending    = r_pending;
  assign overflow   = r_overflow;

endmodule

// File: doc/priority_event_encoder.md
Name: priority_event_encoder

Overview:
- Sequential 8-to-3 priority encoder.
- Latches one-hot/multi-hot event requests into a pending register and issues the index of the highest-priority eligible pending event as a binary code over a valid/ready handshake.
- Performs the inverse of the 3-to-8 one-hot priority decode used downstream, so encoded codes can be fed straight back to that decoder.
- Sits between event sources (interrupt/request lines) and a single consumer.

Parameters:
- N, 8, number of request lines.
- W, 3, code width; must equal clog2(N).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  N  per-line event request, sampled every clk edge; each cycle high counts as one event.
- mask  input  N  1 = line not eligible for dispatch; masked lines still latch as pending.
- code  output  W  index of the dispatched event, registered.
- code_valid  output  1  code holds an undelivered event.
- code_ready  input  1  consumer accepts code when code_valid && code_ready.
- pending  output  N  current pending register, registered.
- overflow  output  1  sticky; set when a request hits a line that is already pending.
- clr_ovf  input  1  synchronous clear of overflow.

Behaviour:
- Reset (async, rst_n=0): pending=0, code=0, code_valid=0, overflow=0, FSM=IDLE. All outputs take reset values immediately.
- Eligible vector: elig = pending & ~mask.
- Priority: highest index wins (bit N-1 highest, bit 0 lowest).
- FSM states: IDLE (code_valid=0) and HOLD (code_valid=1).
- IDLE:
  - elig != 0 at an edge: code <= highest set index of elig, code_valid <= 1, that pending bit cleared, go HOLD.
  - elig == 0: stay IDLE.
- HOLD:
  - code and code_valid stay stable until handshake.
  - On handshake with elig != 0: load next highest eligible index in the same edge (back-to-back, no bubble), clear its pending bit, stay HOLD.
  - On handshake with elig == 0: code_valid <= 0, go IDLE. code keeps its last value.
- Pending update each edge: pending <= (pending & ~take) | req, where take is the one-hot of the bit moved to code this edge.
  - req on a bit being taken the same edge leaves that bit set; the new event is kept.
- Latency:
  - req high at edge k sets pending at k.
  - code_valid rises at edge k+1 when idle, unmasked and highest priority.
  - Minimum one cycle from pending to valid.
- Overflow:
  - Set when req[i]=1 and pending[i]=1 and bit i is not taken that edge; the event is coalesced.
  - Also set when req[i]=1, code_valid=1, code==i, no handshake that edge, and pending[i] is already set.
  - clr_ovf=1 clears overflow. A set condition in the same edge wins over clr_ovf.
- Mask changes take effect on the next dispatch decision. A code already in HOLD is never withdrawn by mask.
- Reset mid-HOLD discards the held code and all pending events.
- code is combinationally independent of req; all outputs are registered.

Test Plan:
- Reset: rst_n=0 mid-run with pending=8'hA5 and code_valid=1 -> pending=0, code_valid=0, overflow=0 immediately, without waiting for a clk edge.
- Single event: req=8'h10 for 1 cycle, code_ready=1 -> code=3'd4, code_valid high exactly 1 cycle, pending returns to 0.
- Priority and drain: req=8'h85 for 1 cycle, code_ready=1 -> codes 7, 2, 0 on consecutive cycles, then code_valid=0.
- Backpressure and mask: req=8'h06, mask=8'h04, code_ready=0 for 5 cycles.
  - code=1 held stable for 5 cycles, pending=8'h04.
  - Then mask=0, code_ready=1 -> code 1 accepted, then code 2 accepted.
- Overflow: req=8'h08 on two consecutive cycles while code_ready=0.
  - code=3 held; the second pulse on line 3 sets pending[3] again (event kept).
  - A third pulse on line 3 while pending[3]=1 -> overflow=1.
  - clr_ovf=1 -> overflow=0.
- Simultaneous take and request: pending=8'h40 in IDLE with req[6]=1 on the dispatch edge -> code=6, code_valid=1, pending[6] remains 1, overflow stays 0.
